// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared datapath.
// Optional macro MIPS_MC_JAL_EN adds the JAL state (opcode 000011); without it that opcode is illegal.
module mips_mc_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state
);
    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC_R   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_EXEC_I   = 4'd9;
    localparam logic [3:0] S_I_WB     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_JAL      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    logic [3:0] next_state;
    logic [3:0] dec_next;
    logic       dec_legal;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       waiting;
    logic       timeout_flag;

    // funct is decoded by the ALU control block, not here
    logic unused_funct;
    assign unused_funct = ^funct;

    // Opcode decode: successor of DECODE and whether the opcode is supported
    always_comb begin
        dec_next  = S_FETCH;
        dec_legal = 1'b1;
        case (opcode)
            OP_RTYPE:                           dec_next = S_EXEC_R;
            OP_LW, OP_SW:                       dec_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                     dec_next = S_BRANCH;
            OP_J:                               dec_next = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  dec_next = S_EXEC_I;
`ifdef MIPS_MC_JAL_EN
            OP_JAL:                             dec_next = S_JAL;
`endif
            default: begin
                dec_next  = S_FETCH;
                dec_legal = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state = S_RESET;
        case (state)
            S_RESET:    next_state = S_FETCH;
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   next_state = dec_next;
            S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   next_state = S_R_WB;
            S_R_WB:     next_state = S_FETCH;
            S_EXEC_I:   next_state = S_I_WB;
            S_I_WB:     next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
`ifdef MIPS_MC_JAL_EN
            S_JAL:      next_state = S_FETCH;
`endif
            default:    next_state = S_RESET;
        endcase
    end

    assign waiting = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem_ready;

    // Wait counter: restarts on every state change, saturates at the watchdog limit
    always_comb begin
        if (next_state != state) begin
            wait_cnt_next = 4'd0;
        end else if (waiting && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end else begin
            wait_cnt_next = wait_cnt;
        end
    end

    // State, wait counter and sticky timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RESET;
            wait_cnt     <= 4'd0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= next_state;
            wait_cnt     <= wait_cnt_next;
            timeout_flag <= timeout_flag | (wait_cnt_next == WAIT_MAX);
        end
    end

    // Moore output decode; FETCH, MEM_WR and BRANCH qualify a few outputs by mem_ready/zero
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        pc_source  = 2'd0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                illegal   = ~dec_legal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 2'd1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_dst    = 2'd1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = 2'd1;
                instr_done = 1'b1;
                pc_write   = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
            end
            S_JUMP: begin
                pc_source  = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MIPS_MC_JAL_EN
            S_JAL: begin
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                reg_write  = 1'b1;
                pc_source  = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
        mem_timeout = timeout_flag & (state != S_RESET);
    end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multicycle MIPS control unit. Sequences the shared datapath (single memory port, single ALU, PC/IR registers and their 2:1/3:1/4:1 select muxes) through fetch/decode/execute/memory/writeback states. It drives every mux select and register write-enable, and waits on a memory ready handshake. It sits between the instruction register (opcode/funct source) and the datapath muxes.

Parameters:
MEM_WAIT_MAX, 15, watchdog limit on consecutive cycles waiting for mem_ready; when exceeded, mem_timeout is asserted.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
opcode  input  6  IR[31:26]; stable from DECODE until next FETCH
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, valid in BRANCH
mem_ready  input  1  memory completes access this cycle
pc_write  output  1  PC register enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR enable
reg_dst  output  2  write-register select: 0=rt, 1=rd, 2=$31
mem_to_reg  output  2  write-data select: 0=ALUOut, 1=MDR, 2=PC
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_op  output  3  0=add,1=sub,2=use funct,3=and,4=or,5=slt
pc_source  output  2  0=ALU result, 1=ALUOut, 2=jump target
instr_done  output  1  one-cycle pulse on final cycle of each instruction
illegal  output  1  one-cycle pulse, unsupported opcode in DECODE
mem_timeout  output  1  sticky; cleared only by rst
state  output  4  current state encoding (debug)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State encodings: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, EXEC_I=9, I_WB=10, BRANCH=11, JUMP=12, JAL=13.
- On rst: state<=RESET. In RESET, all outputs are 0, including illegal, instr_done and mem_timeout. The next state is always FETCH.
- Outputs are Moore outputs decoded from state, except where an output is qualified by mem_ready or zero.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000, 001100, 001101 or 001010 -> EXEC_I
  - otherwise: illegal=1 and go to FETCH (instruction dropped, PC already advanced).
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. Go to MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD: mem_read=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Go to FETCH.
- MEM_WR: mem_write=1, iord=1. instr_done=mem_ready. Wait for mem_ready, then go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=funct. Go to R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Go to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2. alu_op by opcode: add (001000), and (001100), or (001101), slt (001010). Go to I_WB.
- I_WB: reg_dst=0, reg_write=1, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_source=1, instr_done=1.
  - pc_write = (opcode==000100 & zero) | (opcode==000101 & ~zero).
  - Go to FETCH.
- JUMP: pc_source=2, pc_write=1, instr_done=1. Go to FETCH.
- Memory request outputs stay asserted and stable every cycle while waiting in FETCH, MEM_RD or MEM_WR.
- Wait counter: 4 bits, cleared on every state change. It increments each waiting cycle with mem_ready=0 and saturates at MEM_WAIT_MAX. Reaching MEM_WAIT_MAX sets mem_timeout; the FSM keeps waiting.
- rst asserted in any state, including mid-wait: RESET on the next edge, wait counter cleared, any pending access abandoned.
- Undefined state codes (14, 15) go to RESET.

Optional Feature:
MIPS_MC_JAL_EN
- Defined: opcode 000011 in DECODE goes to JAL. JAL drives reg_dst=2, mem_to_reg=2, reg_write=1, pc_source=2, pc_write=1, instr_done=1, then goes to FETCH.
- Not defined: 000011 is illegal (illegal pulse, back to FETCH). State code 13 is treated as undefined.

Test Plan:
- Reset: rst=1 for 2 cycles then 0 -> state=0 with all outputs 0; next cycle state=1 with mem_read=1, alu_src_b=1.
- lw (opcode 100011), mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> FETCH held 4 cycles with ir_write only on the last; path 1,2,3,4,5; MEM_WB has reg_write=1, mem_to_reg=1; total 10 cycles.
- beq (000100) with zero=1 -> BRANCH pc_write=1, pc_source=1. bne (000101) with zero=1 -> pc_write=0. Both give instr_done=1.
- R-type add (000000/100000), mem_ready=1 always -> states 1,2,7,8; R_WB reg_dst=1, reg_write=1; 4 cycles per instruction.
- opcode 111111 -> illegal=1 in DECODE, next state FETCH, reg_write never asserted. Hold mem_ready=0 for 20 cycles in FETCH -> mem_timeout=1 after 15 wait cycles, stays 1 until rst.
- With MIPS_MC_JAL_EN: opcode 000011 -> JAL with reg_dst=2, mem_to_reg=2, pc_write=1. Without the macro: illegal=1.
